oled_display_driver: RTL and testbench

- SPI driver for a 96x64 SSD1331-class RGB565 PmodOLED.
- Runs a power-up sequence, then streams full frames continuously, pulling each pixel from upstream logic via pixel_index and pixel_data.
- Sits between the top level and the JA/JC Pmod pins, clocked from the 6.25 MHz divided clock.

---
 rtl/oled_display_driver.sv | 235 +++++++++++++++++++++++
 tb/tb_oled_display_driver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/oled_display_driver.sv
// SPI driver for a 96x64 SSD1331-class RGB565 OLED: power-up, init command ROM, then continuous
// frame streaming with pixels pulled from upstream through pixel_index / pixel_data.
module oled_display_driver #(
  parameter int unsigned RST_LOW_CYCLES  = 32,
  parameter int unsigned RST_HIGH_CYCLES = 32,
  parameter int unsigned VCC_WAIT_CYCLES = 625000,
  parameter int unsigned NUM_PIXELS      = 6144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        frame_begin,
  output logic        sending_pixels,
  output logic        sample_pixel,
  output logic        cs,
  output logic        sdin,
  output logic        sclk,
  output logic        d_cn,
  output logic        resn,
  output logic        vccen,
  output logic        pmoden
);

  localparam int unsigned MaxRst  = (RST_LOW_CYCLES > RST_HIGH_CYCLES) ? RST_LOW_CYCLES
                                                                       : RST_HIGH_CYCLES;
  localparam int unsigned MaxWait = (MaxRst > VCC_WAIT_CYCLES) ? MaxRst : VCC_WAIT_CYCLES;
  localparam int unsigned CntW    = (MaxWait < 2) ? 1 : $clog2(MaxWait);

  // Command ROM layout: init sequence, display-on, then the per-frame window command.
  localparam logic [5:0]  InitLast   = 6'd35;
  localparam logic [5:0]  DispOnIdx  = 6'd36;
  localparam logic [5:0]  FrameFirst = 6'd37;
  localparam logic [5:0]  FrameLast  = 6'd42;
  localparam logic [12:0] LastPixel  = 13'(NUM_PIXELS - 1);

  typedef enum logic [3:0] {
    StPwrOn, StRstRel, StInit, StVccWait, StDispOn, StFrameGap, StFrameCmd, StPixStart, StPixels
  } state_e;

  function automatic logic [7:0] rom_byte(input logic [5:0] idx);
    logic [7:0] b;
    case (idx)
      6'd0:  b = 8'hAE;  6'd1:  b = 8'hA0;  6'd2:  b = 8'h72;  6'd3:  b = 8'hA1;
      6'd4:  b = 8'h00;  6'd5:  b = 8'hA2;  6'd6:  b = 8'h00;  6'd7:  b = 8'hA4;
      6'd8:  b = 8'hA8;  6'd9:  b = 8'h3F;  6'd10: b = 8'hAD;  6'd11: b = 8'h8E;
      6'd12: b = 8'hB0;  6'd13: b = 8'h0B;  6'd14: b = 8'hB1;  6'd15: b = 8'h31;
      6'd16: b = 8'hB3;  6'd17: b = 8'hF0;  6'd18: b = 8'h8A;  6'd19: b = 8'h64;
      6'd20: b = 8'h8B;  6'd21: b = 8'h78;  6'd22: b = 8'h8C;  6'd23: b = 8'h64;
      6'd24: b = 8'hBB;  6'd25: b = 8'h3A;  6'd26: b = 8'hBE;  6'd27: b = 8'h3E;
      6'd28: b = 8'h87;  6'd29: b = 8'h06;  6'd30: b = 8'h81;  6'd31: b = 8'h91;
      6'd32: b = 8'h82;  6'd33: b = 8'h50;  6'd34: b = 8'h83;  6'd35: b = 8'h7D;
      6'd36: b = 8'hAF;
      6'd37: b = 8'h15;  6'd38: b = 8'h00;  6'd39: b = 8'h5F;  6'd40: b = 8'h75;
      6'd41: b = 8'h00;  6'd42: b = 8'h3F;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      ph_q, ph_d;
  logic [15:0]     sh_q, sh_d;
  logic [5:0]      byte_idx_q, byte_idx_d;
  logic [12:0]     pix_idx_q, pix_idx_d;
  logic            resn_q, resn_d;
  logic            vccen_q, vccen_d;
  logic            pmoden_q, pmoden_d;
  logic [12:0]     next_pix;

  assign next_pix = (pix_idx_q == LastPixel) ? 13'd0 : pix_idx_q + 13'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ph_d       = ph_q;
    sh_d       = sh_q;
    byte_idx_d = byte_idx_q;
    pix_idx_d  = pix_idx_q;
    resn_d     = resn_q;
    vccen_d    = vccen_q;
    pmoden_d   = 1'b1;
    case (state_q)
      StPwrOn: begin
        if (cnt_q == CntW'(RST_LOW_CYCLES - 1)) begin
          state_d = StRstRel;
          cnt_d   = '0;
          resn_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRstRel: begin
        if (cnt_q == CntW'(RST_HIGH_CYCLES - 1)) begin
          state_d    = StInit;
          byte_idx_d = 6'd0;
          sh_d       = {rom_byte(6'd0), 8'h00};
          ph_d       = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StInit, StDispOn, StFrameCmd: begin
        if (ph_q[3:0] != 4'hF) begin
          ph_d = ph_q + 5'd1;
          // Shift on the high->low transition so sdin moves with the falling sclk.
          if (ph_q[0]) sh_d = {sh_q[14:0], 1'b0};
        end else begin
          ph_d = '0;
          if (state_q == StInit && byte_idx_q == InitLast) begin
            state_d = StVccWait;
            cnt_d   = '0;
            vccen_d = 1'b1;
          end else if (state_q == StDispOn) begin
            state_d = StFrameGap;
            cnt_d   = '0;
          end else if (state_q == StFrameCmd && byte_idx_q == FrameLast) begin
            state_d = StPixStart;
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
            sh_d       = {rom_byte(byte_idx_q + 6'd1), 8'h00};
          end
        end
      end
      StVccWait: begin
        if (cnt_q == CntW'(VCC_WAIT_CYCLES - 1)) begin
          state_d    = StDispOn;
          byte_idx_d = DispOnIdx;
          sh_d       = {rom_byte(DispOnIdx), 8'h00};
          ph_d       = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFrameGap: begin
        if (cnt_q == CntW'(1)) begin
          state_d    = StFrameCmd;
          byte_idx_d = FrameFirst;
          sh_d       = {rom_byte(FrameFirst), 8'h00};
          ph_d       = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPixStart: begin
        state_d   = StPixels;
        sh_d      = pixel_data;
        pix_idx_d = next_pix;
        ph_d      = '0;
      end
      StPixels: begin
        if (ph_q != 5'd31) begin
          ph_d = ph_q + 5'd1;
          if (ph_q[0]) sh_d = {sh_q[14:0], 1'b0};
        end else if (pix_idx_q == 13'd0) begin
          // Index already wrapped: the pixel just finished was the last one of the frame.
          state_d = StFrameGap;
          cnt_d   = '0;
          ph_d    = '0;
        end else begin
          sh_d      = pixel_data;
          pix_idx_d = next_pix;
          ph_d      = '0;
        end
      end
      default: state_d = StPwrOn;
    endcase
  end

  always_comb begin
    cs             = 1'b1;
    sclk           = 1'b1;
    sdin           = 1'b0;
    d_cn           = 1'b0;
    frame_begin    = 1'b0;
    sending_pixels = 1'b0;
    sample_pixel   = 1'b0;
    pixel_index    = 13'd0;
    case (state_q)
      StInit, StDispOn, StFrameCmd: begin
        cs   = 1'b0;
        sclk = ph_q[0];
        sdin = sh_q[15];
      end
      StPixStart: begin
        cs             = 1'b0;
        d_cn           = 1'b1;
        frame_begin    = 1'b1;
        sending_pixels = 1'b1;
        sample_pixel   = 1'b1;
        pixel_index    = pix_idx_q;
      end
      StPixels: begin
        cs             = 1'b0;
        sclk           = ph_q[0];
        sdin           = sh_q[15];
        d_cn           = 1'b1;
        sending_pixels = 1'b1;
        sample_pixel   = (ph_q == 5'd31) && (pix_idx_q != 13'd0);
        pixel_index    = pix_idx_q;
      end
      default: ;
    endcase
  end

  assign resn   = resn_q;
  assign vccen  = vccen_q;
  assign pmoden = pmoden_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StPwrOn;
      cnt_q      <= '0;
      ph_q       <= '0;
      sh_q       <= '0;
      byte_idx_q <= '0;
      pix_idx_q  <= '0;
      resn_q     <= 1'b0;
      vccen_q    <= 1'b0;
      pmoden_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      sh_q       <= sh_d;
      byte_idx_q <= byte_idx_d;
      pix_idx_q  <= pix_idx_d;
      resn_q     <= resn_d;
      vccen_q    <= vccen_d;
      pmoden_q   <= pmoden_d;
    end
  end

endmodule

// File: tb/tb_oled_display_driver.sv
// Bench for oled_display_driver: timing table after reset release, SPI byte/word decoding against
// the command list and a random pixel image, and an asynchronous mid-frame reset.
module tb_oled_display_driver;

  localparam int RstLow  = 4;
  localparam int RstHigh = 4;
  localparam int VccWait = 50;
  localparam int NPix    = 24;

  // Cycle numbers (posedges after release) derived from the sequence rules.
  localparam int TInit = RstLow + RstHigh;
  localparam int TVcc  = TInit + 36 * 16;
  localparam int TDisp = TVcc + VccWait;
  localparam int TGap  = TDisp + 16;
  localparam int TCmd  = TGap + 2;
  localparam int TPix  = TCmd + 6 * 16;
  localparam int TEnd  = TPix + 32 * NPix;
  localparam int TCmd2 = TEnd + 3;
  localparam int TPix2 = TCmd2 + 6 * 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic        frame_begin, sending_pixels, sample_pixel, cs, sdin, sclk, d_cn, resn, vccen, pmoden;

  always #5 clk = ~clk;

  oled_display_driver #(
    .RST_LOW_CYCLES (RstLow),
    .RST_HIGH_CYCLES(RstHigh),
    .VCC_WAIT_CYCLES(VccWait),
    .NUM_PIXELS     (NPix)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_data    (pixel_data),
    .pixel_index   (pixel_index),
    .frame_begin   (frame_begin),
    .sending_pixels(sending_pixels),
    .sample_pixel  (sample_pixel),
    .cs            (cs),
    .sdin          (sdin),
    .sclk          (sclk),
    .d_cn          (d_cn),
    .resn          (resn),
    .vccen         (vccen),
    .pmoden        (pmoden)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] init_rom [36] = '{8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00, 8'hA4, 8'hA8,
                                8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hB1, 8'h31, 8'hB3, 8'hF0,
                                8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C, 8'h64, 8'hBB, 8'h3A, 8'hBE,
                                8'h3E, 8'h87, 8'h06, 8'h81, 8'h91, 8'h82, 8'h50, 8'h83, 8'h7D};
  logic [7:0] frame_cmd [6] = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};
  logic [7:0]  exp_b[$];
  logic [15:0] lut[NPix];

  // Timing table: flags = {cs, sclk, d_cn, resn, vccen, pmoden, frame_begin, sending, sample}.
  typedef struct {
    int          cyc;
    logic [8:0]  flags;
    logic [12:0] idx;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input int c, input logic [8:0] f, input logic [12:0] i);
    vec_t v;
    v.cyc = c; v.flags = f; v.idx = i;
    vecs.push_back(v);
  endtask

  // SPI decoder and pixel source.
  logic [7:0]  cmd_q[$];
  logic [15:0] pix_q[$];
  initial begin
    logic       prev_sclk;
    logic [7:0] cacc;
    logic [15:0] pacc;
    int cbits, pbits;
    prev_sclk = 1'b1; cacc = '0; pacc = '0; cbits = 0; pbits = 0;
    pixel_data = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset || cs) begin
        cbits = 0;
        pbits = 0;
      end else if (!prev_sclk && sclk) begin
        if (!d_cn) begin
          cacc = {cacc[6:0], sdin};
          cbits++;
          if (cbits == 8) begin cmd_q.push_back(cacc); cbits = 0; end
        end else begin
          pacc = {pacc[14:0], sdin};
          pbits++;
          if (pbits == 16) begin pix_q.push_back(pacc); pbits = 0; end
        end
      end
      prev_sclk = sclk;
      // Garbage on every non-sample cycle must never reach the shifted stream.
      if (sample_pixel && int'(pixel_index) < NPix) pixel_data = lut[pixel_index];
      else pixel_data = 16'($urandom);
      if (frame_begin || sample_pixel) chk("pulse_in_pixel_phase", 32'(sending_pixels), 32'd1);
    end
  end

  task automatic chk_reset_vals(input string name);
    chk(name, {9'd0, cs, sclk, sdin, d_cn, resn, vccen, pmoden, frame_begin, sending_pixels,
               sample_pixel, pixel_index}, {9'd0, 10'b11_0000_0000, 13'd0});
  endtask

  task automatic run_cycles(input int ncyc);
    logic vcc_prev;
    vcc_prev = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      foreach (vecs[k]) begin
        if (vecs[k].cyc == c)
          chk($sformatf("vec@%0d", c),
              {10'd0, cs, sclk, d_cn, resn, vccen, pmoden, frame_begin, sending_pixels,
               sample_pixel, pixel_index},
              {10'd0, vecs[k].flags, vecs[k].idx});
      end
      if (vccen && !vcc_prev) chk("bytes_at_vccen", cmd_q.size(), 32'd36);
      vcc_prev = vccen;
    end
  endtask

  initial begin
    int target;
    bit hit;
    foreach (init_rom[i]) exp_b.push_back(init_rom[i]);
    exp_b.push_back(8'hAF);
    for (int r = 0; r < 2; r++) foreach (frame_cmd[i]) exp_b.push_back(frame_cmd[i]);
    foreach (lut[i]) lut[i] = 16'($urandom);

    add_vec(1,         9'b110001000, 13'd0);
    add_vec(RstLow-1,  9'b110001000, 13'd0);
    add_vec(RstLow,    9'b110101000, 13'd0);
    add_vec(TInit-1,   9'b110101000, 13'd0);
    add_vec(TInit,     9'b000101000, 13'd0);
    add_vec(TInit+1,   9'b010101000, 13'd0);
    add_vec(TVcc-1,    9'b010101000, 13'd0);
    add_vec(TVcc,      9'b110111000, 13'd0);
    add_vec(TDisp-1,   9'b110111000, 13'd0);
    add_vec(TDisp,     9'b000111000, 13'd0);
    add_vec(TGap+1,    9'b110111000, 13'd0);
    add_vec(TCmd,      9'b000111000, 13'd0);
    add_vec(TPix-1,    9'b010111000, 13'd0);
    add_vec(TPix,      9'b011111111, 13'd0);
    add_vec(TPix+1,    9'b001111010, 13'd1);
    add_vec(TPix+32,   9'b011111011, 13'd1);
    add_vec(TPix+33,   9'b001111010, 13'd2);
    add_vec(TEnd-32,   9'b011111011, 13'(NPix-1));
    add_vec(TEnd-31,   9'b001111010, 13'd0);
    add_vec(TEnd,      9'b011111010, 13'd0);
    add_vec(TEnd+1,    9'b110111000, 13'd0);
    add_vec(TCmd2,     9'b000111000, 13'd0);
    add_vec(TPix2,     9'b011111111, 13'd0);

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_hold");
    reset = 1'b1;
    cmd_q.delete();
    pix_q.delete();
    run_cycles(TPix2 + 2);

    chk("cmd_count", cmd_q.size(), exp_b.size());
    foreach (exp_b[i]) if (i < cmd_q.size()) chk($sformatf("cmd%0d", i), cmd_q[i], exp_b[i]);
    chk("pix_count", pix_q.size(), NPix);
    foreach (lut[i]) if (i < pix_q.size()) chk($sformatf("pix%0d", i), pix_q[i], lut[i]);

    // Asynchronous reset in the middle of the second frame.
    target = $urandom_range(3, NPix - 3);
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (sending_pixels && int'(pixel_index) == target) hit = 1'b1;
    end
    chk("reach_mid_frame", 32'(hit), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_reset");
    repeat (3) @(negedge clk);
    chk_reset_vals("reset_hold2");
    reset = 1'b1;
    cmd_q.delete();
    pix_q.delete();
    run_cycles(TPix + 1);
    chk("cmd_count_rerun", cmd_q.size(), 32'd43);
    for (int i = 0; i < 43; i++)
      if (i < cmd_q.size()) chk($sformatf("rerun_cmd%0d", i), cmd_q[i], exp_b[i]);
    chk("pix_count_rerun", pix_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
